// File: rtl/pipeline_hazard_arbiter.sv
// Fixed-priority hazard arbiter: picks the highest-index request and drives per-stage
// stall/flush, with one-shot flush suppression, post-reset flush, stall watchdog and perf counters.
//
// state | meaning
// IDLE  | no stage stalled in the previous cycle; watchdog count is zero
// HOLD  | stall asserted in the previous cycle; watchdog count accumulating
module pipeline_hazard_arbiter #(
    parameter int                       N_STAGE       = 6,
    parameter int                       N_REQ         = 4,
    parameter logic [N_REQ*N_STAGE-1:0] STALL_MASK    = 24'h3C7083,
    parameter logic [N_REQ*N_STAGE-1:0] FLUSH_MASK    = 24'h408184,
    parameter logic [N_REQ-1:0]         FLUSH_ONESHOT = 4'b0110,
    parameter logic [N_STAGE-1:0]       RST_FLUSH     = 6'h1F,
    parameter int                       TMO_W         = 16,
    parameter int                       CNT_W         = 32,
    localparam int                      ID_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [TMO_W-1:0]   tmo_limit_i,
    input  logic               clr_i,
    output logic [N_STAGE-1:0] stall_o,
    output logic [N_STAGE-1:0] flush_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   stall_cycles_o,
    output logic [CNT_W-1:0]   flush_events_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Masks viewed as one N_STAGE-wide entry per request, request 0 in the LSBs.
    localparam logic [N_REQ-1:0][N_STAGE-1:0] STALL_TAB = STALL_MASK;
    localparam logic [N_REQ-1:0][N_STAGE-1:0] FLUSH_TAB = FLUSH_MASK;

    logic [N_REQ-1:0]   req_act;
    logic               any_req;
    logic [ID_W-1:0]    win_id;
    logic [N_STAGE-1:0] stall_sel;
    logic [N_STAGE-1:0] flush_sel;
    logic               oneshot_hit;
    logic               stall_any;

    logic               post_q;
    logic               prev_valid_q;
    logic [ID_W-1:0]    prev_id_q;
    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic [TMO_W-1:0]   wd_cnt_q;
    logic [TMO_W-1:0]   wd_base;
    logic [TMO_W-1:0]   wd_next;
    logic               timeout_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;

    // Requests are masked while reset is held so outputs drop without waiting for a clock.
    assign req_act = rst_n ? req_i : '0;

    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_act[i]) begin
                any_req = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    assign oneshot_hit = FLUSH_ONESHOT[win_id] && prev_valid_q && (prev_id_q == win_id);

    always_comb begin
        stall_sel = '0;
        flush_sel = '0;
        if (any_req) begin
            stall_sel = STALL_TAB[win_id];
            if (!oneshot_hit) begin
                flush_sel = FLUSH_TAB[win_id];
            end
        end
    end

    assign stall_any  = |stall_sel;
    assign stall_o    = stall_sel;
    assign flush_o    = flush_sel | (post_q ? RST_FLUSH : '0);
    assign grant_o    = any_req ? (N_REQ'(1) << win_id) : '0;
    assign grant_id_o = win_id;
    assign timeout_o  = timeout_q;

    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_q       <= 1'b1;
            prev_valid_q <= 1'b0;
            prev_id_q    <= '0;
        end else begin
            post_q       <= 1'b0;
            prev_valid_q <= any_req;
            prev_id_q    <= win_id;
        end
    end

    // Watchdog: the entering cycle counts as 1, so a limit of L flags after L stalled cycles.
    always_comb begin
        state_d = stall_any ? HOLD : IDLE;
        wd_base = (state_q == HOLD) ? wd_cnt_q : '0;
        wd_next = '0;
        if (stall_any) begin
            wd_next = (wd_base == '1) ? wd_base : wd_base + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_next;
            if (clr_i) begin
                timeout_q <= 1'b0;
            end else if (stall_any && (tmo_limit_i != '0) && (wd_next >= tmo_limit_i)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o[0] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if ((|flush_o) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
